// File: rtl/shift_op_sequencer_pkg.sv
// Shared constants and types for the Mini SRC shift/rotate sequencer.
// Opcodes, op_sel bit positions, FSM state type and op decode helpers.
package mini_src_pkg;

  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;

  localparam int SEL_SHR  = 0;
  localparam int SEL_SHRA = 1;
  localparam int SEL_SHL  = 2;
  localparam int SEL_ROR  = 3;
  localparam int SEL_ROL  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_ERR
  } state_e;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

  function automatic logic [4:0] op_decode(input logic [4:0] op);
    logic [4:0] d;
    d = '0;
    case (op)
      OP_SHR:  d[SEL_SHR]  = 1'b1;
      OP_SHRA: d[SEL_SHRA] = 1'b1;
      OP_SHL:  d[SEL_SHL]  = 1'b1;
      OP_ROR:  d[SEL_ROR]  = 1'b1;
      OP_ROL:  d[SEL_ROL]  = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_op_sequencer_if.sv
// Control-unit <-> sequencer bundle: decoded IR request in, datapath strobes out.
// master = control unit / testbench side, slave = sequencer.
interface shift_op_sequencer_if #(
  parameter int NREGS    = 16,
  parameter int REG_BITS = 4
);
  logic                start;
  logic [4:0]          opcode;
  logic [REG_BITS-1:0] ra;
  logic [REG_BITS-1:0] rb;
  logic [REG_BITS-1:0] rc;
  logic                hold;
  logic [NREGS-1:0]    reg_out_sel;
  logic [NREGS-1:0]    reg_in_sel;
  logic                y_in;
  logic                z_in;
  logic                zlow_out;
  logic [4:0]          op_sel;
  logic                busy;
  logic                done;
  logic                illegal;

  modport master (
    output start, opcode, ra, rb, rc, hold,
    input  reg_out_sel, reg_in_sel, y_in, z_in, zlow_out, op_sel, busy, done, illegal
  );

  modport slave (
    input  start, opcode, ra, rb, rc, hold,
    output reg_out_sel, reg_in_sel, y_in, z_in, zlow_out, op_sel, busy, done, illegal
  );
endinterface

// File: rtl/shift_op_sequencer_reg_decoder.sv
// Register index to one-hot strobe decoder; all-zero when disabled.
module reg_decoder #(
  parameter int REG_BITS = 4,
  parameter int NREGS    = 16
) (
  input  logic                en,
  input  logic [REG_BITS-1:0] idx,
  output logic [NREGS-1:0]    onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/shift_op_sequencer.sv
// Execute-phase (T3..T5) sequencer for shr/shra/shl/ror/rol: drives bus
// strobes and the shifter's one-hot op select; non-shift opcodes end in ERR.
module shift_op_sequencer
  import mini_src_pkg::*;
#(
  parameter int NREGS    = 16,
  parameter int REG_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  shift_op_sequencer_if.slave  bus
);

  state_e              state, nxt;
  logic [4:0]          op_q;
  logic [REG_BITS-1:0] ra_q, rb_q, rc_q;
  logic                accept;

  logic                rd_en, wr_en;
  logic [REG_BITS-1:0] rd_idx;
  logic                y_in, z_in, zlow_out, busy, done, illegal;
  logic [4:0]          op_sel;

  // hold in IDLE blocks acceptance, so a held start is never latched
  assign accept = (state == ST_IDLE) && bus.start && !bus.hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q <= bus.opcode;
        ra_q <= bus.ra;
        rb_q <= bus.rb;
        rc_q <= bus.rc;
      end
    end
  end

  always_comb begin
    nxt      = state;
    rd_en    = 1'b0;
    rd_idx   = rb_q;
    wr_en    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    op_sel   = '0;
    busy     = (state != ST_IDLE);
    done     = 1'b0;
    illegal  = 1'b0;
    case (state)
      ST_IDLE: if (accept) nxt = is_shift(bus.opcode) ? ST_T3 : ST_ERR;
      ST_T3: begin
        rd_en = 1'b1;
        y_in  = 1'b1;
        nxt   = ST_T4;
      end
      ST_T4: begin
        rd_en  = 1'b1;
        rd_idx = rc_q;
        op_sel = op_decode(op_q);
        z_in   = 1'b1;
        nxt    = ST_T5;
      end
      ST_T5: begin
        zlow_out = 1'b1;
        wr_en    = 1'b1;
        done     = 1'b1;
        nxt      = ST_IDLE;
      end
      ST_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
        nxt     = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    // Stall: keep bus drivers steady but suppress every load/pulse so each fires once
    if (bus.hold) begin
      nxt     = state;
      y_in    = 1'b0;
      z_in    = 1'b0;
      wr_en   = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

  reg_decoder #(.REG_BITS(REG_BITS), .NREGS(NREGS)) u_rd_dec (
    .en     (rd_en),
    .idx    (rd_idx),
    .onehot (bus.reg_out_sel)
  );

  reg_decoder #(.REG_BITS(REG_BITS), .NREGS(NREGS)) u_wr_dec (
    .en     (wr_en),
    .idx    (ra_q),
    .onehot (bus.reg_in_sel)
  );

  assign bus.y_in     = y_in;
  assign bus.z_in     = z_in;
  assign bus.zlow_out = zlow_out;
  assign bus.op_sel   = op_sel;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.illegal  = illegal;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed + randomized check of shift_op_sequencer against a queue-of-steps model.
module tb_shift_op_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  shift_op_sequencer_if #(.NREGS(16), .REG_BITS(4)) bus ();

  shift_op_sequencer #(.NREGS(16), .REG_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] out_sel;
    logic [15:0] in_sel;
    logic        y;
    logic        z;
    logic        zlow;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        ill;
  } exp_t;

  // Remaining execute cycles of the current instruction; front is the present cycle.
  exp_t steps[$];
  int   done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got=%h want=%h", tag, $time, got, want);
    end
  endtask

  function automatic bit model_is_shift(input logic [4:0] op);
    return op >= 5'd7 && op <= 5'd11;
  endfunction

  task automatic push_instr(input logic [4:0] op, input logic [3:0] a, b, c);
    exp_t e;
    if (model_is_shift(op)) begin
      e = '0; e.busy = 1; e.out_sel = 16'(1) << b; e.y = 1;
      steps.push_back(e);
      e = '0; e.busy = 1; e.out_sel = 16'(1) << c; e.z = 1;
      e.op = 5'(1) << (op - 5'd7);
      steps.push_back(e);
      e = '0; e.busy = 1; e.zlow = 1; e.in_sel = 16'(1) << a; e.done = 1;
      steps.push_back(e);
    end else begin
      e = '0; e.busy = 1; e.done = 1; e.ill = 1;
      steps.push_back(e);
    end
  endtask

  // One clock: drive at negedge, check 1ns later, then advance model at posedge.
  task automatic cyc(input logic rs, st, hd, input logic [4:0] op,
                     input logic [3:0] a, b, c);
    exp_t e;
    @(negedge clock);
    reset = rs; bus.start = st; bus.hold = hd;
    bus.opcode = op; bus.ra = a; bus.rb = b; bus.rc = c;
    #1;
    e = (steps.size() > 0) ? steps[0] : exp_t'('0);
    if (hd) begin
      e.y = 0; e.z = 0; e.in_sel = '0; e.done = 0; e.ill = 0;
    end
    chk("reg_out_sel", 32'(bus.reg_out_sel), 32'(e.out_sel));
    chk("reg_in_sel",  32'(bus.reg_in_sel),  32'(e.in_sel));
    chk("y_in",        32'(bus.y_in),        32'(e.y));
    chk("z_in",        32'(bus.z_in),        32'(e.z));
    chk("zlow_out",    32'(bus.zlow_out),    32'(e.zlow));
    chk("op_sel",      32'(bus.op_sel),      32'(e.op));
    chk("busy",        32'(bus.busy),        32'(e.busy));
    chk("done",        32'(bus.done),        32'(e.done));
    chk("illegal",     32'(bus.illegal),     32'(e.ill));
    if (bus.done) done_cnt++;
    @(posedge clock);
    if (rs) steps.delete();
    else if (!hd) begin
      if (steps.size() > 0) void'(steps.pop_front());
      else if (st) push_instr(op, a, b, c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    bus.start = 0; bus.hold = 0; bus.opcode = '0; bus.ra = '0; bus.rb = '0; bus.rc = '0;
    done_cnt = 0;
    @(posedge clock);
    // reset for two cycles
    cyc(1, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    // shr r3, r5, r6
    cyc(0, 1, 0, 5'b00111, 4'd3, 4'd5, 4'd6);
    idle(3);
    // remaining shift opcodes
    for (int k = 8; k <= 11; k++) begin
      cyc(0, 1, 0, 5'(k), 4'(k), 4'(k + 1), 4'(k + 2));
      idle(3);
    end
    // illegal opcode, then an immediate restart two cycles after start
    cyc(0, 1, 0, 5'b00011, 4'd1, 4'd2, 4'd3);
    cyc(0, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    cyc(0, 1, 0, 5'b01001, 4'd15, 4'd0, 4'd15);
    idle(3);
    // hold for 3 cycles on entry to T4
    cyc(0, 1, 0, 5'b00111, 4'd2, 4'd4, 4'd8);
    cyc(0, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5'd0, 4'd0, 4'd0, 4'd0);
    idle(3);
    // simultaneous start and hold in IDLE: not latched
    cyc(0, 1, 1, 5'b01010, 4'd1, 4'd1, 4'd1);
    idle(1);
    // reset in T4, with a start during busy that must be ignored
    done_cnt = 0;
    cyc(0, 1, 0, 5'b01011, 4'd7, 4'd7, 4'd7);
    cyc(0, 1, 0, 5'b00111, 4'd1, 4'd2, 4'd3);
    cyc(1, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    idle(4);
    chk("done_after_reset", 32'(done_cnt), 32'd0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(7, 11));
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 4) == 0), op,
          4'($urandom), 4'($urandom), 4'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
